// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: debounces mode/inc/cancel, edits an hh:mm:ss BCD shadow and commits it.
// Optional auto-repeat of the inc button is built only when TIME_SET_AUTOREPEAT_EN is defined.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_HALF      = 12500000
`ifdef TIME_SET_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_cancel,
  input  logic [3:0] cur_sec_ge,
  input  logic [3:0] cur_sec_shi,
  input  logic [3:0] cur_min_ge,
  input  logic [3:0] cur_min_shi,
  input  logic [3:0] cur_hour_ge,
  input  logic [3:0] cur_hour_shi,
  output logic [3:0] set_sec_ge,
  output logic [3:0] set_sec_shi,
  output logic [3:0] set_min_ge,
  output logic [3:0] set_min_shi,
  output logic [3:0] set_hour_ge,
  output logic [3:0] set_hour_shi,
  output logic       set_time_finish,
  output logic       editing,
  output logic [5:0] blink_mask
);

  // state     | meaning
  // IDLE      | not editing, waiting for mode
  // EDIT_HOUR | inc advances hour field
  // EDIT_MIN  | inc advances minute field
  // EDIT_SEC  | inc advances second field
  // COMMIT    | one-cycle load of set_* from shadow
  typedef enum logic [2:0] {IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);

  state_t      state, state_next;
  logic [23:0] shadow, shadow_next;
  logic [23:0] set_q;

  logic [2:0]  btn_raw;
  logic [2:0]  sync1, sync2, db_lvl, db_prev, press_ev;
  logic [DB_W-1:0] db_cnt [3];

  logic mode_ev, inc_ev, cancel_ev;
  logic edit_st, state_chg;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  assign btn_raw = {btn_cancel, btn_inc, btn_mode};

  // Index 0 = mode, 1 = inc, 2 = cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      db_lvl   <= '0;
      db_prev  <= '0;
      press_ev <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      db_prev  <= db_lvl;
      press_ev <= db_lvl & ~db_prev;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_lvl[i] <= ~db_lvl[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign mode_ev   = press_ev[0];
  assign cancel_ev = press_ev[2];
  assign edit_st   = (state == EDIT_HOUR) || (state == EDIT_MIN) || (state == EDIT_SEC);
  assign state_chg = (state_next != state);

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_armed;
  logic             rep_ev;

  always_ff @(posedge clk) begin
    if (rst || !db_lvl[1] || !edit_st || state_chg) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      rep_ev    <= 1'b0;
    end else begin
      rep_ev <= 1'b0;
      if (!rep_armed && rep_cnt == REP_W'(REPEAT_DELAY - 1)) begin
        rep_ev    <= 1'b1;
        rep_armed <= 1'b1;
        rep_cnt   <= '0;
      end else if (rep_armed && rep_cnt == REP_W'(REPEAT_PERIOD - 1)) begin
        rep_ev  <= 1'b1;
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  assign inc_ev = press_ev[1] | rep_ev;
`else
  assign inc_ev = press_ev[1];
`endif

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] top_shi,
                                          input logic [3:0] top_ge);
    if (v[7:4] == top_shi && v[3:0] == top_ge) return 8'h00;
    else if (v[3:0] == 4'd9)                   return {v[7:4] + 4'd1, 4'd0};
    else                                       return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    state_next  = state;
    shadow_next = shadow;
    case (state)
      IDLE: begin
        if (mode_ev) begin
          shadow_next = {cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge,
                         cur_sec_shi, cur_sec_ge};
          state_next  = EDIT_HOUR;
        end
      end
      EDIT_HOUR: begin
        if (cancel_ev)    state_next = IDLE;
        else if (mode_ev) state_next = EDIT_MIN;
        else if (inc_ev)  shadow_next[23:16] = bcd_inc(shadow[23:16], 4'd2, 4'd3);
      end
      EDIT_MIN: begin
        if (cancel_ev)    state_next = IDLE;
        else if (mode_ev) state_next = EDIT_SEC;
        else if (inc_ev)  shadow_next[15:8] = bcd_inc(shadow[15:8], 4'd5, 4'd9);
      end
      EDIT_SEC: begin
        if (cancel_ev)    state_next = IDLE;
        else if (mode_ev) state_next = COMMIT;
        else if (inc_ev)  shadow_next[7:0] = bcd_inc(shadow[7:0], 4'd5, 4'd9);
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
      set_q  <= '0;
    end else begin
      state  <= state_next;
      shadow <= shadow_next;
      if (state == COMMIT) set_q <= shadow;
    end
  end

  // Phase restarts at 0 on every edit-state entry, including field-to-field moves
  always_ff @(posedge clk) begin
    if (rst || state_chg || !edit_st) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    blink_mask = 6'b000000;
    if (blink_phase) begin
      case (state)
        EDIT_HOUR: blink_mask = 6'b110000;
        EDIT_MIN:  blink_mask = 6'b001100;
        EDIT_SEC:  blink_mask = 6'b000011;
        default:   blink_mask = 6'b000000;
      endcase
    end
  end

  assign editing         = edit_st;
  assign set_time_finish = (state == COMMIT);

  assign {set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge} = set_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized bench for time_set_ctrl: an arithmetic time model feeds a commit scoreboard.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_cancel = 1'b0;
  logic [3:0] cur_sec_ge = '0, cur_sec_shi = '0, cur_min_ge = '0, cur_min_shi = '0;
  logic [3:0] cur_hour_ge = '0, cur_hour_shi = '0;
  logic [3:0] set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi;
  logic       set_time_finish, editing;
  logic [5:0] blink_mask;

  time_set_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_HALF(8)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_cancel(btn_cancel),
    .cur_sec_ge(cur_sec_ge), .cur_sec_shi(cur_sec_shi),
    .cur_min_ge(cur_min_ge), .cur_min_shi(cur_min_shi),
    .cur_hour_ge(cur_hour_ge), .cur_hour_shi(cur_hour_shi),
    .set_sec_ge(set_sec_ge), .set_sec_shi(set_sec_shi),
    .set_min_ge(set_min_ge), .set_min_shi(set_min_shi),
    .set_hour_ge(set_hour_ge), .set_hour_shi(set_hour_shi),
    .set_time_finish(set_time_finish), .editing(editing), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [23:0] exp_q[$];
  logic [23:0] last_set = '0;
  logic        pend = 1'b0;
  logic [23:0] pend_val = '0;
  logic [23:0] set_bus;

  assign set_bus = {set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge};

  function automatic logic [23:0] pack_time(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Commit monitor: every pulse must match a queued expectation, value checked one cycle later
  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      chk("commit_value", set_bus, pend_val);
      chk("finish_one_cycle", 24'(set_time_finish), 24'd0);
    end else if (set_time_finish === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got set_time_finish=1 expected no commit");
      end else begin
        pend_val = exp_q.pop_front();
        pend     = 1'b1;
      end
    end
  end

  task automatic set_cur(input int h, input int m, input int s);
    {cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge} = pack_time(h, m, s);
  endtask

  // b = {cancel, inc, mode}
  task automatic press(input logic [2:0] b);
    @(negedge clk);
    {btn_cancel, btn_inc, btn_mode} = b;
    repeat (8) @(negedge clk);
    {btn_cancel, btn_inc, btn_mode} = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_n(input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  // Holds a button and checks press latency plus the blink phase counted from state entry
  task automatic hold_check(input logic [2:0] b, input logic [5:0] fmask, input logic pre_edit);
    @(negedge clk);
    {btn_cancel, btn_inc, btn_mode} = b;
    repeat (7) @(negedge clk);
    chk("latency_before", 24'(editing), 24'(pre_edit));
    @(negedge clk);
    chk("latency_after", 24'(editing), 24'd1);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      chk("blink_phase", 24'(blink_mask), 24'(((i / 8) % 2 == 1) ? fmask : 6'b000000));
    end
    {btn_cancel, btn_inc, btn_mode} = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  task automatic edit_txn(input int h, input int m, input int s,
                          input int dh, input int dm, input int ds);
    logic [23:0] e;
    set_cur(h, m, s);
    press(3'b001);
    chk("enter_edit", 24'(editing), 24'd1);
    press_n(3'b010, dh);
    press(3'b001);
    press_n(3'b010, dm);
    press(3'b001);
    press_n(3'b010, ds);
    e = pack_time((h + dh) % 24, (m + dm) % 60, (s + ds) % 60);
    exp_q.push_back(e);
    last_set = e;
    press(3'b001);
    chk("commit_seen", 24'(exp_q.size()), 24'd0);
    chk("idle_after_commit", 24'(editing), 24'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("reset_set", set_bus, 24'd0);
    chk("reset_editing", 24'(editing), 24'd0);
    chk("reset_blink", 24'(blink_mask), 24'd0);
    chk("reset_finish", 24'(set_time_finish), 24'd0);

    // Bounce rejection, then a clean hold captures 12:34:56 regardless of later cur changes
    set_cur(12, 34, 56);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      btn_mode = 1'b1;
      repeat (3) @(negedge clk);
      btn_mode = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("bounce_ignored", 24'(editing), 24'd0);
    btn_mode = 1'b1;
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_enters_edit", 24'(editing), 24'd1);
    set_cur(1, 2, 3);
    exp_q.push_back(pack_time(12, 34, 56));
    last_set = pack_time(12, 34, 56);
    press_n(3'b001, 3);
    chk("capture_commit_seen", 24'(exp_q.size()), 24'd0);

    // Wrap cases and tens carries
    edit_txn(23, 59, 58, 1, 1, 3);
    edit_txn(9, 9, 0, 1, 1, 0);
    edit_txn(19, 58, 59, 1, 1, 1);

    // Press latency and blink phase on hour and minute entry
    set_cur(7, 8, 9);
    hold_check(3'b001, 6'b110000, 1'b0);
    hold_check(3'b001, 6'b001100, 1'b1);
    press(3'b100);
    chk("blink_exit", 24'(blink_mask), 24'd0);
    chk("cancel_exit", 24'(editing), 24'd0);

    // Cancel from EDIT_MIN discards the edit
    set_cur(10, 20, 30);
    press_n(3'b001, 2);
    press_n(3'b010, 2);
    press(3'b100);
    chk("cancel_idle", 24'(editing), 24'd0);
    chk("cancel_blink", 24'(blink_mask), 24'd0);
    chk("cancel_hold_set", set_bus, last_set);

    // Mode and cancel together in EDIT_SEC: cancel wins
    set_cur(3, 4, 5);
    press_n(3'b001, 3);
    press(3'b101);
    chk("cancel_priority_idle", 24'(editing), 24'd0);
    chk("cancel_priority_set", set_bus, last_set);

    // Reset during EDIT_MIN
    press_n(3'b001, 2);
    chk("pre_reset_edit", 24'(editing), 24'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_mid_editing", 24'(editing), 24'd0);
    chk("reset_mid_set", set_bus, 24'd0);
    chk("reset_mid_blink", 24'(blink_mask), 24'd0);
    last_set = '0;
    repeat (10) @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      edit_txn(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    chk("final_set", set_bus, last_set);
    chk("queue_empty", 24'(exp_q.size()), 24'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
